// File: rtl/csi_pixel_unpack.sv
// csi_pixel_unpack
// MIPI CSI-2 payload-to-pixel unpacker. Payload bytes arrive LANES per beat
// under lv_in, are buffered in a DEPTH-byte ring, and leave as one 10-bit
// pixel per cycle, either RAW8 (byte << 2) or RAW10 (4 pixels per 5 bytes).
//
// Ports:
//   clk        single clock for all logic
//   rstn       synchronous reset, active low
//   din        LANES payload bytes, din[7:0] is the earliest byte
//   lv_in      input beat valid
//   fv_in      input frame valid
//   mode       0 = RAW8, 1 = RAW10, latched at frame start
//   pixdata    output pixel
//   lv_out     pixdata valid
//   fv_out     output frame valid
//   ovf        sticky overflow (a whole beat was dropped)
//   resid_err  sticky, partial RAW10 group left at frame end
//
// Build option: define RAW10_EN to build the RAW10 path and resid_err.
// Without it the block is RAW8 only, mode is ignored and resid_err is 0.
module csi_pixel_unpack #(
  parameter int LANES = 2,
  parameter int DEPTH = 2048
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [LANES*8-1:0] din,
  input  logic               lv_in,
  input  logic               fv_in,
  input  logic               mode,
  output logic [9:0]         pixdata,
  output logic               lv_out,
  output logic               fv_out,
  output logic               ovf,
  output logic               resid_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] LANES_C = CW'(LANES);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [7:0]    ring [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          fv_q;

  logic          frame_start;
  logic          accept;
  logic          has_room;
  logic          push;
  logic          pop8;
  logic          frame_end;
  logic [AW-1:0] wr_base;
  logic [CW-1:0] count_base;
  logic [CW-1:0] n_push;
  logic [CW-1:0] n_pop;
  logic [CW-1:0] count_next;
  logic [7:0]    rd_b0;

`ifdef RAW10_EN
  typedef enum logic {S_IDLE, S_EMIT} state_t;

  state_t     state;
  logic [1:0] idx;
  logic       mode_q;
  logic [7:0] grp_p [4];
  logic [7:0] grp_l;
  logic       load;
  logic       emit_step;
  logic [1:0] idx_nxt;
  logic [7:0] rd_b1;
  logic [7:0] rd_b2;
  logic [7:0] rd_b3;
  logic [7:0] rd_b4;
`else
  logic unused_mode;
  assign unused_mode = mode;
  assign resid_err   = 1'b0;
`endif

  // Frame start acts as a clear: the ring is treated as empty at address 0
  // for this cycle, so a beat arriving with the rising fv_in lands at 0.
  // Beats outside an active frame are ignored without raising ovf.
  always_comb begin
    frame_start = fv_in & ~fv_q;
    accept      = lv_in & (fv_out | frame_start);
    count_base  = frame_start ? '0 : count;
    wr_base     = frame_start ? '0 : wr_ptr;
    has_room    = (DEPTH_C - count_base) >= LANES_C;
    push        = accept & has_room;
    n_push      = push ? LANES_C : '0;
    rd_b0       = ring[rd_ptr];
    pop8        = 1'b0;
    frame_end   = 1'b0;
    n_pop       = '0;
`ifdef RAW10_EN
    rd_b1     = ring[rd_ptr + AW'(1)];
    rd_b2     = ring[rd_ptr + AW'(2)];
    rd_b3     = ring[rd_ptr + AW'(3)];
    rd_b4     = ring[rd_ptr + AW'(4)];
    idx_nxt   = idx + 2'd1;
    load      = 1'b0;
    emit_step = 1'b0;
    if (mode_q) begin
      // A group is fetched from IDLE or while the last pixel of the previous
      // group is on the output, which keeps back-to-back groups gap-free.
      load      = fv_out & ~frame_start & (count >= CW'(5)) &
                  ((state == S_IDLE) | (idx == 2'd3));
      emit_step = ~frame_start & (state == S_EMIT) & (idx != 2'd3);
      n_pop     = load ? CW'(5) : '0;
      frame_end = fv_out & ~fv_in & (state == S_IDLE) & (count < CW'(5));
    end else begin
      pop8      = fv_out & ~frame_start & (count != '0);
      frame_end = fv_out & ~fv_in & (count == '0);
    end
`else
    pop8      = fv_out & ~frame_start & (count != '0);
    frame_end = fv_out & ~fv_in & (count == '0);
`endif
    if (pop8) begin
      n_pop = CW'(1);
    end
    count_next = count_base + n_push - n_pop;
  end

  // Ring storage; pure data, so it carries no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      for (int i = 0; i < LANES; i++) begin
        ring[wr_base + AW'(i)] <= din[i*8 +: 8];
      end
    end
  end

  // Pointers, occupancy, frame tracking and the registered pixel outputs.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      fv_q    <= 1'b0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      pixdata <= '0;
      lv_out  <= 1'b0;
      fv_out  <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      fv_q   <= fv_in;
      wr_ptr <= wr_base + (push ? AW'(LANES) : '0);
      rd_ptr <= frame_start ? '0 : rd_ptr + AW'(n_pop);
      count  <= count_next;
      lv_out <= 1'b0;
      if (frame_start) begin
        fv_out <= 1'b1;
        ovf    <= 1'b0;
      end else begin
        if (accept & ~has_room) begin
          ovf <= 1'b1;
        end
        if (frame_end) begin
          fv_out <= 1'b0;
        end
      end
      if (pop8) begin
        pixdata <= {rd_b0, 2'b00};
        lv_out  <= 1'b1;
      end
`ifdef RAW10_EN
      else if (load) begin
        pixdata <= {rd_b0, rd_b4[1:0]};
        lv_out  <= 1'b1;
      end else if (emit_step) begin
        pixdata <= {grp_p[idx_nxt], grp_l[{idx_nxt, 1'b0} +: 2]};
        lv_out  <= 1'b1;
      end
`endif
    end
  end

`ifdef RAW10_EN
  // RAW10 group sequencer. idx is the pixel currently on pixdata; pixel 0 is
  // formed straight from the ring during the load so it appears one cycle
  // after the group is fetched.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= S_IDLE;
      idx       <= 2'd0;
      mode_q    <= 1'b0;
      resid_err <= 1'b0;
    end else if (frame_start) begin
      state     <= S_IDLE;
      idx       <= 2'd0;
      mode_q    <= mode;
      resid_err <= 1'b0;
    end else begin
      if (load) begin
        state <= S_EMIT;
        idx   <= 2'd0;
      end else if (emit_step) begin
        idx <= idx_nxt;
      end else if (state == S_EMIT) begin
        state <= S_IDLE;
      end
      if (frame_end && (count != '0)) begin
        resid_err <= 1'b1;
      end
    end
  end

  // Group register, loaded with the five bytes popped for a group.
  always_ff @(posedge clk) begin
    if (load) begin
      grp_p[0] <= rd_b0;
      grp_p[1] <= rd_b1;
      grp_p[2] <= rd_b2;
      grp_p[3] <= rd_b3;
      grp_l    <= rd_b4;
    end
  end
`endif

endmodule

// File: tb/tb_csi_pixel_unpack.sv
module tb_csi_pixel_unpack;

  localparam int LANES   = 2;
  localparam int DEPTH   = 2048;
  localparam int O_LANES = 4;
  localparam int O_DEPTH = 16;
`ifdef RAW10_EN
  localparam bit HAS_RAW10 = 1'b1;
`else
  localparam bit HAS_RAW10 = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rstn;
  logic [LANES*8-1:0] din;
  logic               lv_in, fv_in, mode;
  logic [9:0]         pixdata;
  logic               lv_out, fv_out, ovf, resid_err;

  logic [O_LANES*8-1:0] o_din;
  logic                 o_lv_in, o_fv_in;
  logic [9:0]           o_pixdata;
  logic                 o_lv_out, o_fv_out, o_ovf, o_resid_err;

  int tests_run    = 0;
  int tests_failed = 0;
  int pix_seen     = 0;

  // Reference model: expected pixel stream plus bytes of an unfinished group.
  logic [9:0] exp_q[$];
  logic [7:0] pend_q[$];
  bit         cur_raw10;

  csi_pixel_unpack #(.LANES(LANES), .DEPTH(DEPTH)) u_dut (
    .clk(clk), .rstn(rstn), .din(din), .lv_in(lv_in), .fv_in(fv_in),
    .mode(mode), .pixdata(pixdata), .lv_out(lv_out), .fv_out(fv_out),
    .ovf(ovf), .resid_err(resid_err)
  );

  csi_pixel_unpack #(.LANES(O_LANES), .DEPTH(O_DEPTH)) u_ovf (
    .clk(clk), .rstn(rstn), .din(o_din), .lv_in(o_lv_in), .fv_in(o_fv_in),
    .mode(1'b0), .pixdata(o_pixdata), .lv_out(o_lv_out), .fv_out(o_fv_out),
    .ovf(o_ovf), .resid_err(o_resid_err)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
               name, actual, expected, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // RAW8: one pixel per byte. RAW10: every 5 bytes P0..P3,L give 4 pixels
  // {Pk, L[2k+1:2k]}.
  task automatic modelByte(input logic [7:0] b);
    logic [7:0] l;
    if (!cur_raw10) begin
      exp_q.push_back({b, 2'b00});
    end else begin
      pend_q.push_back(b);
      if (pend_q.size() == 5) begin
        l = pend_q[4];
        for (int k = 0; k < 4; k++) exp_q.push_back({pend_q[k], l[2*k +: 2]});
        pend_q.delete();
      end
    end
  endtask

  task automatic beginFrame(input bit m);
    cur_raw10 = m && HAS_RAW10;
    pend_q.delete();
  endtask

  task automatic applyStimulus(input logic f, input logic l,
                               input logic [LANES*8-1:0] d, input logic m);
    tick();
    fv_in = f;
    lv_in = l;
    din   = d;
    mode  = m;
    if (f && l) begin
      for (int i = 0; i < LANES; i++) modelByte(d[8*i +: 8]);
    end
  endtask

  task automatic finishFrame(input string tag);
    bit done = 1'b0;
    applyStimulus(1'b0, 1'b0, '0, mode);
    for (int n = 0; n < 3000 && !done; n++) begin
      @(negedge clk);
      if (!fv_out) done = 1'b1;
      else tick();
    end
    checkOutput({tag, " fv_out fall"}, done, 1);
    checkOutput({tag, " model drained"}, exp_q.size(), 0);
    checkOutput({tag, " resid_err"}, resid_err, (cur_raw10 && pend_q.size() != 0));
    checkOutput({tag, " ovf"}, ovf, 0);
  endtask

  task automatic runRandomFrame(input bit m, input int nbeats, input int gap_pct);
    beginFrame(m);
    applyStimulus(1'b1, 1'b1, LANES*8'($urandom), m);
    for (int i = 1; i < nbeats; i++) begin
      applyStimulus(1'b1, ($urandom_range(99) >= gap_pct), LANES*8'($urandom), m);
    end
    finishFrame("random frame");
  endtask

  // Every valid output pixel is compared against the model stream.
  always @(negedge clk) begin
    if (rstn && lv_out) begin
      pix_seen++;
      if (exp_q.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("[TB] FAIL pixel stream: got 0x%0h, expected no pixel at %0t",
                 pixdata, $time);
      end else begin
        checkOutput("pixel stream", pixdata, exp_q.pop_front());
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got time limit, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [9:0] lits [4];
    int first, last, nlv, shown, pix_start;
    bit done;

    rstn = 1'b0; din = '0; lv_in = 1'b0; fv_in = 1'b0; mode = 1'b0;
    o_din = '0; o_lv_in = 1'b0; o_fv_in = 1'b0;
    tick(); tick();
    @(negedge clk);
    checkOutput("reset pixdata", pixdata, 0);
    checkOutput("reset lv_out", lv_out, 0);
    checkOutput("reset fv_out", fv_out, 0);
    checkOutput("reset ovf", ovf, 0);
    checkOutput("reset resid_err", resid_err, 0);
    tick();
    rstn = 1'b1;
    repeat (3) tick();

    // RAW8 directed: one beat with the frame start, pixels at cycles 2 and 3.
    beginFrame(1'b0);
    applyStimulus(1'b1, 1'b1, 16'hB2A1, 1'b0); @(negedge clk);
    applyStimulus(1'b1, 1'b0, '0, 1'b0); @(negedge clk);
    checkOutput("raw8 no pixel at cycle 1", lv_out, 0);
    applyStimulus(1'b1, 1'b0, '0, 1'b0); @(negedge clk);
    checkOutput("raw8 lv_out cycle 2", lv_out, 1);
    checkOutput("raw8 pixel A1", pixdata, 10'h284);
    applyStimulus(1'b1, 1'b0, '0, 1'b0); @(negedge clk);
    checkOutput("raw8 lv_out cycle 3", lv_out, 1);
    checkOutput("raw8 pixel B2", pixdata, 10'h2C8);
    applyStimulus(1'b0, 1'b0, '0, 1'b0); @(negedge clk);
    checkOutput("raw8 fv_out held", fv_out, 1);
    applyStimulus(1'b0, 1'b0, '0, 1'b0); @(negedge clk);
    checkOutput("raw8 fv_out fall", fv_out, 0);
    checkOutput("raw8 resid_err", resid_err, 0);
    repeat (2) applyStimulus(1'b0, 1'b0, '0, 1'b0);

`ifdef RAW10_EN
    // RAW10 directed: 6 bytes, pixels on cycles 4..7, one residual byte.
    lits = '{10'h040, 10'h081, 10'h0C2, 10'h103};
    beginFrame(1'b1);
    applyStimulus(1'b1, 1'b1, 16'h2010, 1'b1); @(negedge clk);
    applyStimulus(1'b1, 1'b1, 16'h4030, 1'b1); @(negedge clk);
    applyStimulus(1'b1, 1'b1, 16'h00E4, 1'b1); @(negedge clk);
    applyStimulus(1'b1, 1'b0, '0, 1'b1); @(negedge clk);
    checkOutput("raw10 no pixel at cycle 3", lv_out, 0);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, 1'b0, '0, 1'b1); @(negedge clk);
      checkOutput("raw10 lv_out", lv_out, 1);
      checkOutput("raw10 pixel", pixdata, lits[k]);
    end
    applyStimulus(1'b1, 1'b0, '0, 1'b1); @(negedge clk);
    checkOutput("raw10 no pixel at cycle 8", lv_out, 0);
    finishFrame("raw10 directed");
    checkOutput("raw10 residual flagged", resid_err, 1);

    // RAW10 continuous: 10 bytes back-to-back give 8 gap-free pixels.
    beginFrame(1'b1);
    first = -1; last = -1; nlv = 0;
    for (int c = 0; c < 16; c++) begin
      applyStimulus(1'b1, (c < 5), LANES*8'($urandom), 1'b1);
      @(negedge clk);
      if (lv_out) begin
        nlv++;
        if (first < 0) first = c;
        last = c;
      end
    end
    checkOutput("raw10 continuous count", nlv, 8);
    checkOutput("raw10 continuous span", last - first + 1, 8);
    checkOutput("raw10 continuous first", first, 4);
    finishFrame("raw10 continuous");
`endif

    for (int f = 0; f < 8; f++) begin
      runRandomFrame(f[0], $urandom_range(120, 10), $urandom_range(60, 0));
      repeat (2) applyStimulus(1'b0, 1'b0, '0, 1'b0);
    end

    // Three 1000-byte RAW8 lines in one frame: crosses the ring wrap.
    pix_start = pix_seen;
    beginFrame(1'b0);
    for (int ln = 0; ln < 3; ln++) begin
      for (int b = 0; b < 500; b++) applyStimulus(1'b1, 1'b1, LANES*8'($urandom), 1'b0);
      for (int g = 0; g < 30; g++) applyStimulus(1'b1, 1'b0, '0, 1'b0);
    end
    finishFrame("wrap");
    checkOutput("wrap pixel total", pix_seen - pix_start, 3000);
    repeat (2) applyStimulus(1'b0, 1'b0, '0, 1'b0);

    // Overflow on the small instance: 4 bytes in, 1 out per cycle.
    tick(); o_fv_in = 1'b1; o_lv_in = 1'b1; o_din = 32'($urandom);
    for (int c = 1; c < 8; c++) begin
      tick(); o_din = 32'($urandom);
      @(negedge clk);
      if (c == 4) checkOutput("ovf clear before drop", o_ovf, 0);
      if (c == 5) checkOutput("ovf set after drop", o_ovf, 1);
    end
    tick(); o_lv_in = 1'b0; o_fv_in = 1'b0;
    done = 1'b0;
    for (int n = 0; n < 60 && !done; n++) begin
      @(negedge clk);
      if (!o_fv_out) done = 1'b1;
      else tick();
    end
    checkOutput("ovf frame end", done, 1);
    checkOutput("ovf sticky", o_ovf, 1);
    tick(); o_fv_in = 1'b1; @(negedge clk);
    checkOutput("ovf held until frame start", o_ovf, 1);
    tick(); o_fv_in = 1'b0; @(negedge clk);
    checkOutput("ovf cleared by frame start", o_ovf, 0);
    checkOutput("ovf instance resid_err", o_resid_err, 0);
    repeat (4) tick();

    // Synchronous reset while the third pixel is on the output.
    beginFrame(1'b1);
    shown = 0;
    for (int c = 0; c < 30 && shown < 3; c++) begin
      applyStimulus(1'b1, (c < 3), LANES*8'($urandom), 1'b1);
      @(negedge clk);
      if (lv_out) shown++;
    end
    checkOutput("reset test reached pixel 3", shown, 3);
    rstn = 1'b0; fv_in = 1'b0; lv_in = 1'b0;
    tick();
    rstn = 1'b1;
    exp_q.delete();
    pend_q.delete();
    @(negedge clk);
    checkOutput("mid reset lv_out", lv_out, 0);
    checkOutput("mid reset fv_out", fv_out, 0);
    checkOutput("mid reset pixdata", pixdata, 0);
    checkOutput("mid reset resid_err", resid_err, 0);
    nlv = 0;
    for (int c = 0; c < 6; c++) begin
      tick(); @(negedge clk);
      if (lv_out || fv_out) nlv++;
    end
    checkOutput("quiet after reset", nlv, 0);

    runRandomFrame(1'b0, 40, 20);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
